// File: rtl/vr_router_pkg.sv
// Shared router types: port index, one-hot port vector and per-output lock state.
package vr_router_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PORT_W    = $clog2(NUM_PORTS);

  typedef logic [PORT_W-1:0]    port_idx_t;
  typedef logic [NUM_PORTS-1:0] port_vec_t;

  typedef enum logic {
    SA_IDLE,
    SA_LOCKED
  } lock_state_t;

  function automatic port_idx_t next_idx(port_idx_t i);
    return (i == port_idx_t'(NUM_PORTS - 1)) ? '0 : i + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant and crossbar-control bundle between input buffers and the switch allocator.
interface switch_allocator_if;
  import vr_router_pkg::*;

  port_vec_t                 req;
  port_vec_t [NUM_PORTS-1:0] req_port;
  port_vec_t                 req_tail;
  port_vec_t                 out_credit;
  port_vec_t                 grant;
  port_vec_t [NUM_PORTS-1:0] xbar_mapping;
  port_vec_t                 xbar_valid;

  modport master (
    output req, req_port, req_tail, out_credit,
    input  grant, xbar_mapping, xbar_valid
  );

  modport slave (
    input  req, req_port, req_tail, out_credit,
    output grant, xbar_mapping, xbar_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping upward.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (enable && !found && req[IDX_W'(idx)]) begin
        grant[IDX_W'(idx)] = 1'b1;
        winner             = IDX_W'(idx);
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable round-robin switch allocator; packet locking compiled in with SA_PACKET_LOCK_EN.
module switch_allocator
  import vr_router_pkg::*;
(
  input logic               clk,
  input logic               reset,
  switch_allocator_if.slave bus
);

  port_vec_t [NUM_PORTS-1:0] eff;         // per input: lowest requested output, gated by req
  port_vec_t [NUM_PORTS-1:0] req_by_out;  // per output: which inputs want it
  port_vec_t [NUM_PORTS-1:0] arb_gnt;
  port_vec_t [NUM_PORTS-1:0] out_gnt;
  port_idx_t [NUM_PORTS-1:0] arb_win;
  port_idx_t [NUM_PORTS-1:0] win;
  port_idx_t [NUM_PORTS-1:0] ptr_q, ptr_d;
  port_vec_t [NUM_PORTS-1:0] map_q;
  port_vec_t                 valid_q;
  port_vec_t                 arb_en;
  port_vec_t                 gnt_any;
  port_vec_t                 grant;

`ifdef SA_PACKET_LOCK_EN
  lock_state_t               state_q [NUM_PORTS];
  lock_state_t               state_d [NUM_PORTS];
  port_idx_t [NUM_PORTS-1:0] owner_q, owner_d;
`else
  logic unused_tail;
  assign unused_tail = ^bus.req_tail;
`endif

  always_comb begin
    eff        = '0;
    req_by_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.req[i]) eff[i] = bus.req_port[i] & (~bus.req_port[i] + port_vec_t'(1));
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) req_by_out[o][i] = eff[i][o];
    end
  end

  always_comb begin
    arb_en = bus.out_credit & {NUM_PORTS{~reset}};
`ifdef SA_PACKET_LOCK_EN
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == SA_LOCKED) arb_en[o] = 1'b0;
    end
`endif
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(
      .NUM_REQ(NUM_PORTS)
    ) u_arb (
      .req   (req_by_out[o]),
      .ptr   (ptr_q[o]),
      .enable(arb_en[o]),
      .grant (arb_gnt[o]),
      .winner(arb_win[o])
    );
  end

  always_comb begin
    out_gnt = arb_gnt;
    win     = arb_win;
`ifdef SA_PACKET_LOCK_EN
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == SA_LOCKED) begin
        out_gnt[o] = '0;
        win[o]     = owner_q[o];
        if (bus.out_credit[o] && !reset && req_by_out[o][owner_q[o]]) begin
          out_gnt[o][owner_q[o]] = 1'b1;
        end
      end
    end
`endif
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_any[o] = |out_gnt[o];
      grant      = grant | out_gnt[o];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef SA_PACKET_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
`endif
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt_any[o]) begin
`ifdef SA_PACKET_LOCK_EN
        // A tail releases the output whether it was locked or a single-flit packet.
        if (bus.req_tail[win[o]]) begin
          state_d[o] = SA_IDLE;
          ptr_d[o]   = next_idx(win[o]);
        end else begin
          state_d[o] = SA_LOCKED;
          owner_d[o] = win[o];
        end
`else
        ptr_d[o] = next_idx(win[o]);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      map_q   <= '0;
      valid_q <= '0;
`ifdef SA_PACKET_LOCK_EN
      for (int o = 0; o < NUM_PORTS; o++) state_q[o] <= SA_IDLE;
      owner_q <= '0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= grant;
      for (int i = 0; i < NUM_PORTS; i++) map_q[i] <= grant[i] ? eff[i] : '0;
`ifdef SA_PACKET_LOCK_EN
      state_q <= state_d;
      owner_q <= owner_d;
`endif
    end
  end

  assign bus.grant        = grant;
  assign bus.xbar_mapping = map_q;
  assign bus.xbar_valid   = valid_q;

endmodule
